// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: pin sync, clock deglitch, frame check,
// and 3-byte packet assembly with click pulse detection.
module ps2_mouse_packet_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       Mouse_Clk,
  input  logic       Mouse_Data,
  output logic       packet_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] x_delta,
  output logic [8:0] y_delta,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       left_click,
  output logic       right_click,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic [FILTER_LEN-1:0]  dat_dly;
  logic                   clk_s;
  logic                   dat_s;
  logic [FW-1:0]          flt_cnt;
  logic                   flt_clk;
  logic                   fall;
  logic                   smp;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Sync flops reset to the idle-high bus level so release makes no edge
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      dat_dly  <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], Mouse_Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], Mouse_Data};
      dat_dly  <= (dat_dly << 1) | FILTER_LEN'(dat_s);
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      flt_cnt <= '0;
      flt_clk <= 1'b1;
      fall    <= 1'b0;
      smp     <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_s == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        flt_clk <= clk_s;
        fall    <= ~clk_s;
        smp     <= dat_dly[FILTER_LEN-1];
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  state_t        state, state_n;
  logic [3:0]    bit_cnt, cnt_n;
  logic [10:0]   frame, frame_n;
  logic [1:0]    idx;
  logic [TW-1:0] tcnt;
  logic          to_fire;
  logic          frame_ok;
  logic [7:0]    rx_byte;
  logic [7:0]    b0;
  logic [7:0]    bx;
  logic          prev_l;
  logic          prev_r;

  assign rx_byte  = frame[8:1];
  assign frame_ok = !frame[0] && (^frame[9:1]) && frame[10];
  assign to_fire  = (tcnt == TW'(TIMEOUT_CYCLES)) && !fall &&
                    ((state != IDLE) || (idx != 2'd0));

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    frame_n = frame;
    unique case (state)
      IDLE: begin
        if (fall && !smp) begin
          state_n = SHIFT;
          cnt_n   = 4'd1;
          frame_n = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          frame_n[bit_cnt] = smp;
          cnt_n            = bit_cnt + 4'd1;
          if (bit_cnt == 4'd10) state_n = CHECK;
        end
      end
      CHECK: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
    if (to_fire) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      frame   <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      frame   <= frame_n;
    end
  end

  // Saturating idle counter; a falling edge always wins over expiry
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (fall) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      idx          <= '0;
      b0           <= '0;
      bx           <= '0;
      prev_l       <= 1'b0;
      prev_r       <= 1'b0;
      packet_valid <= 1'b0;
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_middle   <= 1'b0;
      x_delta      <= '0;
      y_delta      <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
      left_click   <= 1'b0;
      right_click  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      left_click   <= 1'b0;
      right_click  <= 1'b0;
      frame_err    <= 1'b0;
      if (to_fire) begin
        idx <= '0;
      end else if (state == CHECK) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          idx       <= '0;
        end else begin
          unique case (1'b1)
            (idx == 2'd0): begin
              if (rx_byte[3]) begin
                b0  <= rx_byte;
                idx <= 2'd1;
              end else begin
                frame_err <= 1'b1;
              end
            end
            (idx == 2'd1): begin
              bx  <= rx_byte;
              idx <= 2'd2;
            end
            default: begin
              idx          <= '0;
              packet_valid <= 1'b1;
              btn_left     <= b0[0];
              btn_right    <= b0[1];
              btn_middle   <= b0[2];
              x_delta      <= {b0[4], bx};
              y_delta      <= {b0[5], rx_byte};
              x_ovf        <= b0[6];
              y_ovf        <= b0[7];
              left_click   <= b0[0] & ~prev_l;
              right_click  <= b0[1] & ~prev_r;
              prev_l       <= b0[0];
              prev_r       <= b0[1];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx: packets, errors,
// resync, timeout and clock glitch rejection.
module tb_ps2_mouse_packet_rx;

  localparam int TO = 2000;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       packet_valid;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic [8:0] x_delta;
  logic [8:0] y_delta;
  logic       x_ovf;
  logic       y_ovf;
  logic       left_click;
  logic       right_click;
  logic       frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int pv_n   = 0;
  int lc_n   = 0;
  int rc_n   = 0;
  int fe_n   = 0;
  int bad_n  = 0;
  int pv0, lc0, rc0, fe0;

  ps2_mouse_packet_rx #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_100Mhz(clk),
    .reset       (rst_n),
    .Mouse_Clk   (ps2_clk),
    .Mouse_Data  (ps2_dat),
    .packet_valid(packet_valid),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_middle  (btn_middle),
    .x_delta     (x_delta),
    .y_delta     (y_delta),
    .x_ovf       (x_ovf),
    .y_ovf       (y_ovf),
    .left_click  (left_click),
    .right_click (right_click),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (packet_valid) pv_n++;
    if (left_click) lc_n++;
    if (right_click) rc_n++;
    if (frame_err) fe_n++;
    if ((left_click || right_click) && !packet_valid) bad_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~(^d) ^ flip);
    send_bit(1'b1);
    tick(30);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    send_frame(a, 1'b0);
    send_frame(b, 1'b0);
    send_frame(c, 1'b0);
  endtask

  task automatic snap();
    pv0 = pv_n;
    lc0 = lc_n;
    rc0 = rc_n;
    fe0 = fe_n;
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ps2_dat = k[0];
      tick(7);
      ps2_clk = 1'b0;
      tick(15);
      ps2_clk = 1'b1;
      tick(5);
      #1;
      outs = {packet_valid, btn_left, btn_right, btn_middle, x_delta,
              y_delta, x_ovf, y_ovf, left_click, right_click, frame_err};
      n_chk++;
      if (outs !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_outs[%0d]: got %h want 0", k, outs);
      end
    end
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(100);
    n_chk++;
    if (pv_n + fe_n !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_pulses: got %0d want 0", pv_n + fe_n);
    end
  endtask

  task automatic test_first_packet();
    snap();
    send_pkt(8'h29, 8'h05, 8'hFB);
    n_chk++;
    if (pv_n - pv0 !== 1) begin
      n_fail++;
      $display("FAIL p1_valid: got %0d want 1", pv_n - pv0);
    end
    n_chk++;
    if ({btn_left, btn_right, btn_middle} !== 3'b100) begin
      n_fail++;
      $display("FAIL p1_btns: got %b want 100",
               {btn_left, btn_right, btn_middle});
    end
    n_chk++;
    if (x_delta !== 9'h005) begin
      n_fail++;
      $display("FAIL p1_x: got %h want 005", x_delta);
    end
    n_chk++;
    if (y_delta !== 9'h1FB) begin
      n_fail++;
      $display("FAIL p1_y: got %h want 1fb", y_delta);
    end
    n_chk++;
    if ({lc_n - lc0, rc_n - rc0, fe_n - fe0} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL p1_pulses: got lc=%0d rc=%0d fe=%0d want 1 0 0",
               lc_n - lc0, rc_n - rc0, fe_n - fe0);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    send_pkt(8'h29, 8'h05, 8'hFB);
    send_pkt(8'h08, 8'h00, 8'h00);
    n_chk++;
    if (pv_n - pv0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_valid: got %0d want 2", pv_n - pv0);
    end
    n_chk++;
    if (lc_n - lc0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_lclick: got %0d want 0", lc_n - lc0);
    end
    n_chk++;
    if ({btn_left, x_delta, y_delta} !== 19'd0) begin
      n_fail++;
      $display("FAIL b2b_final: got L=%b x=%h y=%h want 0",
               btn_left, x_delta, y_delta);
    end
  endtask

  task automatic test_parity_err();
    snap();
    send_frame(8'h0A, 1'b0);
    send_frame(8'h01, 1'b1);
    n_chk++;
    if ({fe_n - fe0, pv_n - pv0} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL par_err: got fe=%0d pv=%0d want 1 0",
               fe_n - fe0, pv_n - pv0);
    end
    send_pkt(8'h0A, 8'h01, 8'h01);
    n_chk++;
    if ({pv_n - pv0, rc_n - rc0} !== {32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL par_recover: got pv=%0d rc=%0d want 1 1",
               pv_n - pv0, rc_n - rc0);
    end
    n_chk++;
    if ({btn_right, x_delta, y_delta} !== {1'b1, 9'h001, 9'h001}) begin
      n_fail++;
      $display("FAIL par_vals: got R=%b x=%h y=%h want 1 001 001",
               btn_right, x_delta, y_delta);
    end
  endtask

  task automatic test_resync();
    snap();
    send_frame(8'h00, 1'b0);
    n_chk++;
    if (fe_n - fe0 !== 1) begin
      n_fail++;
      $display("FAIL sync_err: got %0d want 1", fe_n - fe0);
    end
    send_pkt(8'h08, 8'h10, 8'h20);
    n_chk++;
    if ({pv_n - pv0, fe_n - fe0} !== {32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL sync_pkt: got pv=%0d fe=%0d want 1 1",
               pv_n - pv0, fe_n - fe0);
    end
    n_chk++;
    if ({x_delta, y_delta} !== {9'h010, 9'h020}) begin
      n_fail++;
      $display("FAIL sync_vals: got x=%h y=%h want 010 020",
               x_delta, y_delta);
    end
  endtask

  task automatic test_timeout();
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick(TO + 10);
    n_chk++;
    if (fe_n - fe0 !== 0) begin
      n_fail++;
      $display("FAIL to_noerr: got %0d want 0", fe_n - fe0);
    end
    send_pkt(8'h09, 8'h02, 8'h03);
    n_chk++;
    if ({pv_n - pv0, lc_n - lc0} !== {32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL to_pkt: got pv=%0d lc=%0d want 1 1",
               pv_n - pv0, lc_n - lc0);
    end
    n_chk++;
    if ({btn_left, x_delta, y_delta} !== {1'b1, 9'h002, 9'h003}) begin
      n_fail++;
      $display("FAIL to_vals: got L=%b x=%h y=%h want 1 002 003",
               btn_left, x_delta, y_delta);
    end
  endtask

  task automatic test_glitch();
    snap();
    ps2_dat = 1'b0;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(5);
    ps2_dat = 1'b1;
    tick(50);
    n_chk++;
    if (fe_n - fe0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_err: got %0d want 0", fe_n - fe0);
    end
    send_pkt(8'h0A, 8'h04, 8'h05);
    n_chk++;
    if ({pv_n - pv0, rc_n - rc0, fe_n - fe0} !==
        {32'd1, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL glitch_pkt: got pv=%0d rc=%0d fe=%0d want 1 1 0",
               pv_n - pv0, rc_n - rc0, fe_n - fe0);
    end
    n_chk++;
    if ({btn_left, btn_right, x_delta, y_delta} !==
        {1'b0, 1'b1, 9'h004, 9'h005}) begin
      n_fail++;
      $display("FAIL glitch_vals: got L=%b R=%b x=%h y=%h want 0 1 004 005",
               btn_left, btn_right, x_delta, y_delta);
    end
  endtask

  task automatic test_click_align();
    n_chk++;
    if (bad_n !== 0) begin
      n_fail++;
      $display("FAIL click_align: got %0d stray clicks want 0", bad_n);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_packet();
    test_back_to_back();
    test_parity_err();
    test_resync();
    test_timeout();
    test_glitch();
    test_click_align();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_rx.md
# ps2_mouse_packet_rx

Receive-only PS/2 mouse front end. It synchronizes the raw `Mouse_Clk`/`Mouse_Data` pins into the `clock_100Mhz` domain, deglitches the PS/2 clock, deframes 11-bit PS/2 frames and checks them, then assembles 3-byte standard mouse packets. It sits directly upstream of the click-counting 7-segment display logic, which consumes the single-cycle `left_click`/`right_click` pulses in the system clock domain. It never drives the PS/2 bus; stream-mode enable is handled outside this block.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each PS/2 input; minimum 2.
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, 200000: idle cycles (2 ms at 100 MHz) after which a partial frame or partial packet is abandoned.

Ports:
- `clock_100Mhz` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `Mouse_Clk` in 1: raw PS/2 clock pin, asynchronous.
- `Mouse_Data` in 1: raw PS/2 data pin, asynchronous.
- `packet_valid` out 1: one-cycle pulse when a complete packet has been decoded.
- `btn_left`, `btn_right`, `btn_middle` out 1 each: button states from the last valid packet.
- `x_delta`, `y_delta` out 9 each: two's-complement movement, formed as {sign bit, byte}.
- `x_ovf`, `y_ovf` out 1 each: overflow flags from the last valid packet.
- `left_click`, `right_click` out 1 each: one-cycle pulse on the 0->1 transition of the button, coincident with `packet_valid`.
- `frame_err` out 1: one-cycle pulse on a rejected frame or a rejected sync byte.

## Operation
- Synchronize both pins through `SYNC_STAGES` flip-flops. Data uses the same stage count plus the same filter delay, so data stays aligned with the clock.
- Clock filter: the filtered clock takes the synchronized value only after `FILTER_LEN` consecutive equal samples. The filtered clock resets to 1.
- Sample data on each falling edge of the filtered clock.
- Bit FSM states: IDLE, SHIFT, CHECK.
  - IDLE: a sampled 0 (start bit) moves to SHIFT with bit count 1. A sampled 1 is ignored.
  - SHIFT: capture 8 data bits LSB first, then the parity bit, then the stop bit. Sampling the stop bit (bit count 11) moves to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE. The frame is valid when start=0, the 9 bits of data plus parity contain an odd number of ones, and stop=1.
  - An invalid frame pulses `frame_err`, discards the byte, and clears the packet byte index to 0.
- Packet assembly, byte index 0..2:
  - Byte 0 layout: [0]=L, [1]=R, [2]=M, [3]=1 (always), [4]=X sign, [5]=Y sign, [6]=X ovf, [7]=Y ovf.
  - If byte 0 has bit[3]=0, drop it, pulse `frame_err`, and keep the index at 0 (resync).
  - Byte 1 is X; byte 2 is Y.
  - On acceptance of byte 2, all packet outputs update together and `packet_valid` pulses. The index returns to 0.
- Click detection: keep registered previous L and R, reset to 0. `left_click` = new L & ~prev L, and likewise for `right_click`. Both update only on `packet_valid`.
- Timeout: a counter clears on every filtered-clock falling edge. When it reaches `TIMEOUT_CYCLES` while the bit FSM is not in IDLE or the byte index is nonzero, force IDLE and index 0. No `frame_err` is raised for a timeout.
- All outputs are registered.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, the index is 0, counters are 0, and the filtered clock is 1.
- Reset asserted mid-frame or mid-packet discards everything immediately. The first frame accepted after release must start on a genuine start bit.
- A raw `Mouse_Clk` fall reaches the sample point `SYNC_STAGES`+`FILTER_LEN` cycles later (±1 cycle).
- `frame_err` and `packet_valid` are asserted exactly 1 cycle after the stop bit is sampled, i.e. in the cycle after CHECK is entered.
- `packet_valid`, `left_click`, `right_click` and `frame_err` are high for exactly one cycle and never repeat without a new frame.
- Packet outputs hold their values until the next `packet_valid`.
- Any Mouse_Clk pulse shorter than `FILTER_LEN` cycles produces no edge.
- A timeout expiring in the same cycle as a falling edge: the edge wins, and the timeout counter clears.
- Bit count never exceeds 11. The timeout counter saturates and does not wrap.

## Test plan
- Reset held low while toggling the pins -> all outputs stay 0. After release with the pins idle high, no pulses occur.
- Frames 0x29, 0x05, 0xFB, each with correct odd parity -> one `packet_valid` pulse.
  - `btn_left`=1, `x_delta`=9'h005, `y_delta`=9'h1FB (−5).
  - `left_click` pulses alongside; `right_click`=0.
- Repeat the same packet, then send 0x08, 0x00, 0x00 -> two more `packet_valid` pulses.
  - No further `left_click` pulse.
  - Final `btn_left`=0, `x_delta`=0, `y_delta`=0.
- Byte 1 sent with a flipped parity bit -> `frame_err` pulses once, with no `packet_valid`. A following full valid packet 0x0A, 0x01, 0x01 decodes with `right_click` pulsing.
- Byte 0 = 0x00 (bit3 clear) -> `frame_err` pulse and the index stays at 0. The next 0x08, 0x10, 0x20 decodes to `x_delta`=16, `y_delta`=32.
- A 5-bit partial frame, then `TIMEOUT_CYCLES`+10 idle cycles, then a valid packet -> decodes correctly. Separately, a 3-cycle low glitch on `Mouse_Clk` -> no bit sampled and no state change.
